// File: rtl/melody_sequencer.sv
`default_nettype none
// ==========================================================================
// melody_sequencer: walks a 16-entry note ROM, emitting half-period + gate.
// Optional macro MELODY_LOOP_EN: loop at the end marker. Rev 1.0
// ==========================================================================
module melody_sequencer #(
   parameter int TICK_DIV = 500000,
   parameter int GAP_CYC  = 500000,
   parameter int PERIOD_W = 18
) (
   input  logic                iCLK,
   input  logic                iRST_N,
   input  logic                iSTART,
   input  logic                iSTOP,
   output logic [PERIOD_W-1:0] oPERIOD,
   output logic                oGATE,
   output logic                oBUSY,
   output logic                oDONE,
   output logic [3:0]          oNOTE_IDX
);

   localparam int c_PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int c_GAP_W = $clog2(GAP_CYC + 1);
   localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(TICK_DIV - 1);
   localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(GAP_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_PLAY = 3'd2,
      S_GAP  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t                r_state, w_state_nxt;
   logic [3:0]            r_idx, w_idx_nxt;
   logic [PERIOD_W-1:0]   r_period, w_period_nxt;
   logic                  r_gate, w_gate_nxt;
   logic                  r_busy, w_busy_nxt;
   logic                  r_done, w_done_nxt;
   logic [7:0]            r_dur, w_dur_nxt;
   logic [c_PRE_W-1:0]    r_pre, w_pre_nxt;
   logic [c_GAP_W-1:0]    r_gap, w_gap_nxt;
   logic [PERIOD_W-1:0]   w_rom_period;
   logic [7:0]            w_rom_dur;

   // Entries 4..15 are end markers (dur = 0).
   always_comb begin
      w_rom_period = '0;
      w_rom_dur    = 8'd0;
      case (r_idx)
         4'd0: begin w_rom_period = PERIOD_W'(18'd95556); w_rom_dur = 8'd2; end
         4'd1: begin w_rom_period = '0;                   w_rom_dur = 8'd1; end
         4'd2: begin w_rom_period = PERIOD_W'(18'd75843); w_rom_dur = 8'd3; end
         4'd3: begin w_rom_period = PERIOD_W'(18'd63776); w_rom_dur = 8'd2; end
         default: ;
      endcase
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         r_state  <= S_IDLE;
         r_idx    <= 4'd0;
         r_period <= '0;
         r_gate   <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_dur    <= 8'd0;
         r_pre    <= '0;
         r_gap    <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_idx    <= w_idx_nxt;
         r_period <= w_period_nxt;
         r_gate   <= w_gate_nxt;
         r_busy   <= w_busy_nxt;
         r_done   <= w_done_nxt;
         r_dur    <= w_dur_nxt;
         r_pre    <= w_pre_nxt;
         r_gap    <= w_gap_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_idx_nxt    = r_idx;
      w_period_nxt = r_period;
      w_gate_nxt   = r_gate;
      w_done_nxt   = 1'b0;
      w_dur_nxt    = r_dur;
      w_pre_nxt    = r_pre;
      w_gap_nxt    = r_gap;
      case (r_state)
         S_IDLE: begin
            if (iSTART) begin
               w_idx_nxt   = 4'd0;
               w_state_nxt = S_LOAD;
            end
         end
         S_LOAD: begin
            if (w_rom_dur == 8'd0) begin
`ifdef MELODY_LOOP_EN
               w_idx_nxt    = 4'd0;
`else
               w_state_nxt  = S_DONE;
               w_period_nxt = '0;
               w_gate_nxt   = 1'b0;
               w_done_nxt   = 1'b1;
`endif
            end else begin
               w_period_nxt = w_rom_period;
               w_gate_nxt   = |w_rom_period;
               w_dur_nxt    = w_rom_dur;
               w_pre_nxt    = '0;
               w_state_nxt  = S_PLAY;
            end
         end
         S_PLAY: begin
            if (r_pre == c_PRE_LAST) begin
               w_pre_nxt = '0;
               w_dur_nxt = r_dur - 8'd1;
               if (r_dur == 8'd1) begin
                  w_state_nxt = S_GAP;
                  w_gate_nxt  = 1'b0;
                  w_gap_nxt   = '0;
               end
            end else begin
               w_pre_nxt = r_pre + c_PRE_W'(1);
            end
         end
         S_GAP: begin
            if (r_gap == c_GAP_LAST) begin
               w_idx_nxt   = r_idx + 4'd1;
               w_state_nxt = S_LOAD;
            end else begin
               w_gap_nxt = r_gap + c_GAP_W'(1);
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
      // Abort wins over everything, including a start in IDLE.
      if (iSTOP) begin
         w_state_nxt  = S_IDLE;
         w_idx_nxt    = r_idx;
         w_period_nxt = '0;
         w_gate_nxt   = 1'b0;
         w_done_nxt   = 1'b0;
      end
      w_busy_nxt = (w_state_nxt == S_LOAD) || (w_state_nxt == S_PLAY) ||
                   (w_state_nxt == S_GAP);
   end

   assign oPERIOD   = r_period;
   assign oGATE     = r_gate;
   assign oBUSY     = r_busy;
   assign oDONE     = r_done;
   assign oNOTE_IDX = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_melody_sequencer.sv
`default_nettype none
// tb_melody_sequencer: directed and random start/stop/reset stimulus checked
// against a note-timeline reference model.
module tb_melody_sequencer;

   localparam int c_TICK = 4;
   localparam int c_GAP  = 2;
   localparam int K_IDLE = 0, K_LOAD = 1, K_PLAY = 2, K_GAP = 3, K_DONE = 4;

   logic        iCLK = 1'b0;
   logic        iRST_N = 1'b0;
   logic        iSTART = 1'b0;
   logic        iSTOP = 1'b0;
   logic [17:0] oPERIOD;
   logic        oGATE, oBUSY, oDONE;
   logic [3:0]  oNOTE_IDX;

   melody_sequencer #(.TICK_DIV(c_TICK), .GAP_CYC(c_GAP), .PERIOD_W(18)) dut (
      .iCLK(iCLK), .iRST_N(iRST_N), .iSTART(iSTART), .iSTOP(iSTOP),
      .oPERIOD(oPERIOD), .oGATE(oGATE), .oBUSY(oBUSY), .oDONE(oDONE),
      .oNOTE_IDX(oNOTE_IDX)
   );

   always #5 iCLK = ~iCLK;

   int rom_per [16];
   int rom_dur [16];
   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;

   bit m_act;
   int m_c, m_kind, m_idx, m_period;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, act, exp);
      end
   endtask

   // Cycle count of one full pass up to and including the end-marker LOAD.
   function automatic int loop_len();
      int pos = 1;
      for (int i = 0; i < 16; i++) begin
         if (rom_dur[i] == 0) return pos;
         pos += 1 + rom_dur[i] * c_TICK + c_GAP;
      end
      return pos;
   endfunction

   // Phase and note index at cycle c after the start edge (c = 1 is the first LOAD).
   function automatic void model_at(input int c, output int kind, output int idx);
      int pos, cc;
      cc = c;
`ifdef MELODY_LOOP_EN
      cc = ((c - 1) % loop_len()) + 1;
`endif
      pos = 1;
      kind = K_IDLE;
      idx = 0;
      for (int i = 0; i < 16; i++) begin
         idx = i;
         if (rom_dur[i] == 0) begin
            if (cc == pos) kind = K_LOAD;
            else if (cc == pos + 1) kind = K_DONE;
            else kind = K_IDLE;
            return;
         end
         if (cc == pos) begin kind = K_LOAD; return; end
         if (cc <= pos + rom_dur[i] * c_TICK) begin kind = K_PLAY; return; end
         if (cc <= pos + rom_dur[i] * c_TICK + c_GAP) begin kind = K_GAP; return; end
         pos += 1 + rom_dur[i] * c_TICK + c_GAP;
      end
   endfunction

   task automatic check_all();
      check_val("period", 32'(oPERIOD), 32'(m_period));
      check_val("gate", 32'(oGATE), 32'((m_kind == K_PLAY) && (m_period != 0)));
      check_val("busy", 32'(oBUSY), 32'((m_kind == K_LOAD) || (m_kind == K_PLAY) || (m_kind == K_GAP)));
      check_val("done", 32'(oDONE), 32'(m_kind == K_DONE));
      check_val("idx", 32'(oNOTE_IDX), 32'(m_idx));
   endtask

   task automatic model_advance();
      int k, ix;
      model_at(m_c, k, ix);
      m_kind = k;
      m_idx  = ix;
      if (k == K_PLAY) m_period = rom_per[ix];
      else if (k == K_DONE || k == K_IDLE) m_period = 0;
      if (k == K_IDLE) m_act = 1'b0;
   endtask

   // Called at a falling edge: drives inputs for the next rising edge, then checks.
   task automatic step(input bit st, input bit sp);
      iSTART = st;
      iSTOP  = sp;
      if (sp) begin
         m_act = 1'b0;
         m_kind = K_IDLE;
         m_period = 0;
      end else if (m_act) begin
         m_c++;
         model_advance();
      end else if (st) begin
         m_act = 1'b1;
         m_c = 1;
         model_advance();
      end
      @(negedge iCLK);
      cyc++;
      check_all();
   endtask

   task automatic model_reset();
      m_act = 1'b0;
      m_c = 0;
      m_kind = K_IDLE;
      m_idx = 0;
      m_period = 0;
   endtask

   task automatic async_reset();
      iSTART = 1'b0;
      iSTOP  = 1'b0;
      #1 iRST_N = 1'b0;
      #2;
      check_val("rst_gate", 32'(oGATE), 32'd0);
      check_val("rst_period", 32'(oPERIOD), 32'd0);
      check_val("rst_busy", 32'(oBUSY), 32'd0);
      check_val("rst_idx", 32'(oNOTE_IDX), 32'd0);
      @(negedge iCLK);
      iRST_N = 1'b1;
      model_reset();
      check_all();
   endtask

   task automatic quiesce();
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         rom_per[i] = 0;
         rom_dur[i] = 0;
      end
      rom_per[0] = 95556; rom_dur[0] = 2;
      rom_per[1] = 0;     rom_dur[1] = 1;
      rom_per[2] = 75843; rom_dur[2] = 3;
      rom_per[3] = 63776; rom_dur[3] = 2;
      model_reset();

      repeat (3) @(negedge iCLK);
      check_all();
      iRST_N = 1'b1;
      for (int i = 0; i < 20; i++) step(1'b0, 1'b0);

      for (int i = 0; i < 60; i++) step(i == 0, 1'b0);
      quiesce();
      for (int i = 0; i < 60; i++) step(i == 0 || i == 15, 1'b0);
      quiesce();
      for (int i = 0; i < 40; i++) step(i == 0, i == 25);
      quiesce();
      for (int i = 0; i < 5; i++) step(i == 0, 1'b0);
      async_reset();
      for (int i = 0; i < 60; i++) step(i == 0, 1'b0);
      quiesce();
      step(1'b1, 1'b1);
      step(1'b0, 1'b0);

      for (int ep = 0; ep < 40; ep++) begin
         for (int i = 0; i < int'($urandom_range(0, 4)); i++)
            step(1'b0, $urandom_range(0, 3) == 0);
         step(1'b1, $urandom_range(0, 7) == 0);
         for (int i = 0; i < 70; i++) begin
            if ($urandom_range(0, 249) == 0) async_reset();
            else step($urandom_range(0, 9) == 0, $urandom_range(0, 99) == 0);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
